// File: rtl/instr_mem_loader.sv
// Instruction memory writer: packs a big-endian byte stream into 32-bit words
// and writes them at sequential word addresses, keeping a running checksum.
module instr_mem_loader #(
  parameter int DEPTH = 128,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] word_idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift;
  logic             start_ok;
  logic             last_word;

  assign byte_ready = (state == COLLECT);
  assign busy       = (state == COLLECT) || (state == WRITE);
  assign start_ok   = (num_words != '0) && (num_words <= CNT_W'(DEPTH));
  assign last_word  = (word_idx == num_lat - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      num_lat   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      shift     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      error     <= 1'b0;
      checksum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              num_lat  <= num_words;
              word_idx <= '0;
              byte_cnt <= '0;
              checksum <= '0;
              error    <= 1'b0;
              state    <= COLLECT;
            end else begin
              error <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (byte_valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shift    <= {shift[15:0], byte_data};
            // Fourth byte goes straight into the write word; no extra cycle.
            if (byte_cnt == 2'd3) begin
              mem_wdata <= {shift, byte_data};
              mem_addr  <= {{(32-CNT_W){1'b0}}, word_idx};
              mem_we    <= 1'b1;
              state     <= WRITE;
            end
          end
        end
        WRITE: begin
          mem_we   <= 1'b0;
          checksum <= checksum + mem_wdata;
          byte_cnt <= '0;
          if (last_word) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            word_idx <= word_idx + CNT_W'(1);
            state    <= COLLECT;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboard bench for instr_mem_loader: driver pushes expected writes,
// a forked monitor pops and compares on every mem_we.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_words = '0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, mem_we, busy, done, error;
  logic [31:0] mem_addr, mem_wdata, checksum;

  instr_mem_loader #(.DEPTH(128), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .num_words(num_words),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t q[$];
  int  tests = 0;
  int  fails = 0;
  int  done_cnt = 0;
  logic stop_mon = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_start(input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1; num_words = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    byte_valid = 1'b1; byte_data = b;
    @(negedge clk);
    while (!byte_ready && t < 100) begin
      @(negedge clk); t++;
    end
    if (!byte_ready) chk("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] w, input bit toggle);
    logic [31:0] wv;
    wv = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(wv[31-8*i -: 8]);
      if (i == 3) begin
        q.push_back('{addr, w});
        chk("we_latency", {31'd0, mem_we}, 32'd1);
      end
      if (toggle) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input string name, input logic [31:0] exp_sum);
    int t = 0;
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    while (!done && t < 2000) begin
      @(negedge clk); t++;
    end
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({name, "_checksum"}, checksum, exp_sum);
    chk({name, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
    chk({name, "_done_pulses"}, done_cnt - d0, 32'd1);
    chk({name, "_q_empty"}, q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      begin : monitor
        wr_t e;
        while (!stop_mon) begin
          @(negedge clk);
          if (done) done_cnt++;
          if (mem_we) begin
            if (q.size() == 0) begin
              tests++; fails++;
              $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_wdata);
            end else begin
              e = q.pop_front();
              chk("write_addr", mem_addr, e.addr);
              chk("write_data", mem_wdata, e.data);
              chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
            end
          end
        end
      end
      begin : stimulus
        logic [31:0] sum;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", {byte_ready, mem_we, busy, done, error}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_checksum", checksum, 32'd0);
        rst = 1'b0;

        // Back-to-back 2-word load
        do_start(8'd2);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send_word(32'd0, 32'hA00000AA, 1'b0);
        send_word(32'd1, 32'h10000011, 1'b0);
        wait_done("t1", 32'hB00000BB);

        // Same load with byte_valid toggling
        do_start(8'd2);
        send_word(32'd0, 32'hA00000AA, 1'b1);
        send_word(32'd1, 32'h10000011, 1'b1);
        wait_done("t2", 32'hB00000BB);

        // Rejected starts, then a good one clears error
        do_start(8'd0);
        chk("t3_err_zero", {30'd0, error, busy}, 32'd2);
        do_start(8'd129);
        chk("t3_err_big", {30'd0, error, busy}, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_sticky", {31'd0, error}, 32'd1);
        do_start(8'd1);
        chk("t3_err_clear", {30'd0, error, busy}, 32'd1);
        send_word(32'd0, 32'h20000022, 1'b0);
        wait_done("t3", 32'h20000022);

        // start mid-load is ignored
        do_start(8'd3);
        send_word(32'd0, 32'h01020304, 1'b0);
        send_byte(8'h05);
        send_byte(8'h06);
        do_start(8'd5);
        chk("t4_err_unaffected", {31'd0, error}, 32'd0);
        send_byte(8'h07);
        send_byte(8'h08);
        q.push_back('{32'd1, 32'h05060708});
        send_word(32'd2, 32'h090A0B0C, 1'b0);
        wait_done("t4", 32'h0F121518);

        // Reset in the middle of word 2
        do_start(8'd2);
        send_word(32'd0, 32'hA00000AA, 1'b0);
        send_byte(8'h10);
        send_byte(8'h00);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_ctrl", {byte_ready, mem_we, busy, done, error}, 32'd0);
        chk("t5_rst_addr", mem_addr, 32'd0);
        chk("t5_rst_wdata", mem_wdata, 32'd0);
        chk("t5_rst_checksum", checksum, 32'd0);
        chk("t5_q_empty", q.size(), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_idle_after_rst", {31'd0, busy}, 32'd0);
        do_start(8'd1);
        send_word(32'd0, 32'h12345678, 1'b0);
        wait_done("t5", 32'h12345678);

        // Full-depth load
        sum = '0;
        do_start(8'd128);
        for (int i = 0; i < 128; i++) begin
          send_word(32'(i), 32'(i), 1'b0);
          sum += 32'(i);
        end
        wait_done("t6", 32'h00001FC0);
        chk("t6_ref_sum", checksum, sum);
        chk("t6_last_addr", mem_addr, 32'h7F);
        repeat (10) @(posedge clk);
        #1;
        chk("t6_idle", {31'd0, busy}, 32'd0);
        stop_mon = 1'b1;
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
Writer side of the instruction memory: accepts a byte stream (valid/ready) from a host or boot source, packs 4 bytes big-endian into 32-bit instruction words, and issues one-cycle word writes at sequential word addresses starting at 0. It sits between the boot/debug byte source and the instruction memory write port, and runs before the MIPS core starts fetching. It also keeps a running checksum for host-side verification.

Parameters:
DEPTH, 128, number of 32-bit words in instruction memory; legal word counts are 1..DEPTH.
CNT_W, 8, width of num_words; must hold DEPTH, i.e. clog2(DEPTH)+1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a load; sampled only in IDLE.
num_words  input  CNT_W  number of words to load; sampled with start.
byte_valid  input  1  byte_data is valid this cycle.
byte_data  input  8  incoming byte, most-significant byte of each word first.
byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both 1.
mem_we  output  1  instruction memory write enable, one cycle per word.
mem_addr  output  32  word address (memory indexed by word), zero-extended.
mem_wdata  output  32  word to write.
busy  output  1  high in COLLECT and WRITE.
done  output  1  one-cycle pulse after the last word is written.
error  output  1  sticky; set on a rejected start, cleared by the next accepted start or by reset.
checksum  output  32  sum mod 2^32 of all words written in the current or last load.

Behaviour:
- Reset (async, any state): state=IDLE; byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, checksum=0; byte and word counters and the shift register cleared. An in-progress load is abandoned with no further writes.
- All outputs are registered except byte_ready and busy, which decode the current state.
- IDLE: byte_ready=0. On start with 1 <= num_words <= DEPTH: latch num_words, word_idx=0, byte_cnt=0, checksum=0, error=0, then go to COLLECT. On start with num_words=0 or num_words>DEPTH: set error=1 and stay in IDLE.
- COLLECT: byte_ready=1. On each transfer: shift <= {shift[23:0], byte_data}, byte_cnt++. When the 4th byte is accepted (byte_cnt==3): go to WRITE, register mem_wdata = the completed word, mem_addr = word_idx, mem_we=1 in the next cycle. Cycles without byte_valid hold state.
- WRITE (exactly 1 cycle): mem_we=1, byte_ready=0, checksum += mem_wdata. Byte_cnt resets to 0. If word_idx == latched num_words-1, go to DONE; otherwise word_idx++ and return to COLLECT.
- Latency: mem_we asserts on the cycle after the 4th byte handshake. The minimum per word is 5 cycles (4 byte cycles + 1 write cycle).
- DONE: done=1 for one cycle, then IDLE. mem_addr, mem_wdata and checksum hold their last values. mem_we returns to 0 after WRITE.
- start while busy or in DONE is ignored, with no effect on error.
- Bytes offered while byte_ready=0 are not consumed. The source must hold them.
- word_idx never exceeds DEPTH-1, so the address never wraps.

Test Plan:
- Reset, start num_words=2, then bytes A0 00 00 AA 10 00 00 11 back-to-back -> writes (addr 0, A00000AA) and (addr 1, 10000011), each with a 1-cycle mem_we; checksum=B00000BB; done pulses once; byte_ready=0 during each WRITE cycle.
- Same load with byte_valid toggling 1/0 every cycle -> identical writes and checksum; no byte is duplicated or dropped; total time is about 2x longer.
- start with num_words=0, then num_words=129 -> error=1, no mem_we, state stays IDLE. Then start with num_words=1 and bytes 20 00 00 22 -> error clears, write (0, 20000022).
- start pulsed again in the middle of a 3-word load with num_words=5 -> ignored; exactly 3 writes at addresses 0..2.
- Assert rst after 6 bytes of a 2-word load -> all outputs drop to 0 immediately, with no second write. A fresh load afterwards starts at addr 0 with checksum reset.
- num_words=128 with incrementing words -> last write at addr 127 (7F), done follows, no write to addr 128; checksum matches the reference sum.
